// File: rtl/alu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | alu_pkg: opsel codes, FSM states and width shared by the ALU       |
// | decoder and the multi-cycle execute unit.                          |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package alu_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SLL   = 3'b001;
  localparam logic [2:0] OP_PASSB = 3'b010;
  localparam logic [2:0] OP_SLT   = 3'b011;
  localparam logic [2:0] OP_XOR   = 3'b100;
  localparam logic [2:0] OP_SR    = 3'b101;
  localparam logic [2:0] OP_OR    = 3'b110;
  localparam logic [2:0] OP_AND   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_shift_step.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | alu_shift_step: one combinational shifter slice, moves a value by  |
// | 0..32 positions left (zero fill) or right (fill bit).              |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module alu_shift_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_value,
  input  logic            i_left,
  input  logic            i_fill,
  input  logic [5:0]      i_amt,
  output logic [XLEN-1:0] o_value
);

  logic [XLEN-1:0] w_fill_mask;

  always_comb begin
    // Ones in exactly the vacated upper positions of a right shift.
    w_fill_mask = i_fill ? ~({XLEN{1'b1}} >> i_amt) : '0;
    o_value     = i_left ? (i_value << i_amt) : ((i_value >> i_amt) | w_fill_mask);
  end

endmodule
`default_nettype wire

// File: rtl/alu_seq_exec.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | alu_seq_exec: multi-cycle ALU execute stage, single-cycle add/     |
// | logic/compare plus an iterative SHIFT_STEP-per-cycle shifter.      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module alu_seq_exec #(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [2:0]      i_opsel,
  input  logic            i_sub,
  input  logic            i_unsigned,
  input  logic            i_arith,
  input  logic [XLEN-1:0] i_op1,
  input  logic [XLEN-1:0] i_op2,
  input  logic            i_flush,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_result,
  output logic            o_eq,
  output logic            o_lt
);

  import alu_pkg::*;

  localparam logic [5:0] c_STEP = 6'(SHIFT_STEP);

  state_t          r_state;
  state_t          w_next;
  logic [XLEN-1:0] r_result;
  logic            r_eq;
  logic            r_lt;
  logic            r_left;
  logic            r_fill;
  logic [5:0]      r_rem;

  logic [XLEN-1:0] w_alu_res;
  logic [XLEN-1:0] w_shifted;
  logic [5:0]      w_amt;
  logic [4:0]      w_shamt;
  logic            w_accept;
  logic            w_is_shift;
  logic            w_start_shift;
  logic            w_eq;
  logic            w_lt;

  assign o_ready  = (r_state == ST_IDLE) && !i_flush;
  assign o_valid  = (r_state == ST_DONE);
  assign o_result = r_result;
  assign o_eq     = r_eq;
  assign o_lt     = r_lt;

  assign w_accept      = i_valid && o_ready;
  assign w_shamt       = i_op2[4:0];
  assign w_is_shift    = (i_opsel == OP_SLL) || (i_opsel == OP_SR);
  assign w_start_shift = w_is_shift && (w_shamt != 5'd0);
  assign w_amt         = (r_rem < c_STEP) ? r_rem : c_STEP;

  always_comb begin
    w_eq = (i_op1 == i_op2);
    w_lt = i_unsigned ? (i_op1 < i_op2) : ($signed(i_op1) < $signed(i_op2));
    case (i_opsel)
      OP_ADD:   w_alu_res = i_sub ? (i_op1 - i_op2) : (i_op1 + i_op2);
      OP_PASSB: w_alu_res = i_op2;
      OP_SLT:   w_alu_res = {{(XLEN-1){1'b0}}, w_lt};
      OP_XOR:   w_alu_res = i_op1 ^ i_op2;
      OP_OR:    w_alu_res = i_op1 | i_op2;
      OP_AND:   w_alu_res = i_op1 & i_op2;
      default:  w_alu_res = i_op1;  // shifts by zero pass op1 through
    endcase
  end

  alu_shift_step #(
    .XLEN (XLEN)
  ) u_shift_step (
    .i_value (r_result),
    .i_left  (r_left),
    .i_fill  (r_fill),
    .i_amt   (w_amt),
    .o_value (w_shifted)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_next = w_start_shift ? ST_SHIFT : ST_DONE;
      end
      ST_SHIFT: begin
        if (i_flush)             w_next = ST_IDLE;
        else if (r_rem == w_amt) w_next = ST_DONE;
      end
      ST_DONE: begin
        if (i_flush || i_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  // r_result doubles as the shift working register while in SHIFT.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_result <= '0;
      r_eq     <= 1'b0;
      r_lt     <= 1'b0;
      r_left   <= 1'b0;
      r_fill   <= 1'b0;
      r_rem    <= '0;
    end else if (r_state == ST_IDLE) begin
      if (w_accept) begin
        r_eq   <= w_eq;
        r_lt   <= w_lt;
        r_left <= (i_opsel == OP_SLL);
        r_fill <= i_arith && i_op1[XLEN-1];
        if (w_start_shift) begin
          r_result <= i_op1;
          r_rem    <= {1'b0, w_shamt};
        end else begin
          r_result <= w_alu_res;
        end
      end
    end else if ((r_state == ST_SHIFT) && !i_flush) begin
      r_result <= w_shifted;
      r_rem    <= r_rem - w_amt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_exec.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_alu_seq_exec: directed vector table plus handshake, flush and   |
// | reset sequences on SHIFT_STEP=4 and SHIFT_STEP=1 instances.        |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_alu_seq_exec;

  typedef struct {
    logic [2:0]  opsel;
    logic        sub;
    logic        uns;
    logic        arith;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] res;
    logic        eq;
    logic        lt;
    int          lat;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  opsel;
  logic        sub, uns, arith, flush;
  logic [31:0] op1, op2;
  logic        sel1, drv_valid, drv_ready;

  logic        valid_in1, valid_in4, ready_in1, ready_in4;
  logic        o_ready1, o_ready4, o_valid1, o_valid4;
  logic        o_eq1, o_eq4, o_lt1, o_lt4;
  logic [31:0] o_res1, o_res4;

  logic        m_ready, m_valid, m_eq, m_lt;
  logic [31:0] m_res;

  int checks = 0;
  int failures = 0;
  vec_t vecs[16];

  always #5 clk = ~clk;

  assign valid_in1 = drv_valid & sel1;
  assign valid_in4 = drv_valid & ~sel1;
  assign ready_in1 = drv_ready & sel1;
  assign ready_in4 = drv_ready & ~sel1;

  always_comb begin
    m_ready = sel1 ? o_ready1 : o_ready4;
    m_valid = sel1 ? o_valid1 : o_valid4;
    m_eq    = sel1 ? o_eq1    : o_eq4;
    m_lt    = sel1 ? o_lt1    : o_lt4;
    m_res   = sel1 ? o_res1   : o_res4;
  end

  alu_seq_exec #(.XLEN(32), .SHIFT_STEP(1)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid_in1), .o_ready(o_ready1),
    .i_opsel(opsel), .i_sub(sub), .i_unsigned(uns), .i_arith(arith),
    .i_op1(op1), .i_op2(op2), .i_flush(flush), .o_valid(o_valid1),
    .i_ready(ready_in1), .o_result(o_res1), .o_eq(o_eq1), .o_lt(o_lt1)
  );

  alu_seq_exec #(.XLEN(32), .SHIFT_STEP(4)) u_dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid_in4), .o_ready(o_ready4),
    .i_opsel(opsel), .i_sub(sub), .i_unsigned(uns), .i_arith(arith),
    .i_op1(op1), .i_op2(op2), .i_flush(flush), .o_valid(o_valid4),
    .i_ready(ready_in4), .o_result(o_res4), .o_eq(o_eq4), .o_lt(o_lt4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic s, input vec_t v, input string name);
    int lat;
    sel1  = s;
    opsel = v.opsel; sub = v.sub; uns = v.uns; arith = v.arith;
    op1   = v.op1;   op2 = v.op2;
    drv_valid = 1'b1;
    check({name, ".ready"}, 32'(m_ready), 32'd1);
    tick();
    drv_valid = 1'b0;
    // Inputs must be captured at accept, so scramble them afterwards.
    op1 = ~v.op1; op2 = ~v.op2; opsel = ~v.opsel; arith = ~v.arith; uns = ~v.uns;
    lat = 1;
    while (!m_valid && lat < 100) begin
      tick();
      lat++;
    end
    check({name, ".lat"}, 32'(lat), 32'(v.lat));
    check({name, ".res"}, m_res, v.res);
    check({name, ".eq"},  32'(m_eq), 32'(v.eq));
    check({name, ".lt"},  32'(m_lt), 32'(v.lt));
    drv_ready = 1'b1;
    tick();
    drv_ready = 1'b0;
    check({name, ".drop"}, 32'(m_valid), 32'd0);
  endtask

  initial begin
    int rises;
    vec_t v;
    //          opsel   sub  uns  ari  op1           op2           res           eq   lt   lat
    vecs[0]  = '{3'b000, 1'b0, 1'b0, 1'b0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0, 1};
    vecs[1]  = '{3'b000, 1'b1, 1'b0, 1'b0, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0, 1'b1, 1};
    vecs[2]  = '{3'b011, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b1, 1};
    vecs[3]  = '{3'b011, 1'b0, 1'b1, 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b0, 1};
    vecs[4]  = '{3'b001, 1'b0, 1'b0, 1'b0, 32'h00000001, 32'h00000000, 32'h00000001, 1'b0, 1'b0, 1};
    vecs[5]  = '{3'b001, 1'b0, 1'b0, 1'b0, 32'h00000001, 32'h00000023, 32'h00000008, 1'b0, 1'b1, 2};
    vecs[6]  = '{3'b100, 1'b0, 1'b1, 1'b0, 32'hA5A5A5A5, 32'h0F0F0F0F, 32'hAAAAAAAA, 1'b0, 1'b0, 1};
    vecs[7]  = '{3'b110, 1'b0, 1'b0, 1'b0, 32'hF0F00000, 32'h00001234, 32'hF0F01234, 1'b0, 1'b1, 1};
    vecs[8]  = '{3'b111, 1'b0, 1'b1, 1'b0, 32'hFFFF0000, 32'h12345678, 32'h12340000, 1'b0, 1'b0, 1};
    vecs[9]  = '{3'b010, 1'b0, 1'b0, 1'b0, 32'h00000003, 32'h00000003, 32'h00000003, 1'b1, 1'b0, 1};
    vecs[10] = '{3'b101, 1'b0, 1'b0, 1'b0, 32'h80000000, 32'h00000004, 32'h08000000, 1'b0, 1'b1, 2};
    vecs[11] = '{3'b101, 1'b0, 1'b0, 1'b1, 32'h80000000, 32'h00000004, 32'hF8000000, 1'b0, 1'b1, 2};
    vecs[12] = '{3'b101, 1'b0, 1'b0, 1'b1, 32'hF0000000, 32'h00000009, 32'hFFF80000, 1'b0, 1'b1, 4};
    vecs[13] = '{3'b101, 1'b0, 1'b0, 1'b1, 32'h40000000, 32'h0000001E, 32'h00000001, 1'b0, 1'b0, 9};
    vecs[14] = '{3'b001, 1'b0, 1'b0, 1'b0, 32'h00000003, 32'h0000001F, 32'h80000000, 1'b0, 1'b1, 9};
    vecs[15] = '{3'b000, 1'b1, 1'b1, 1'b0, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b1, 1};

    rst_n = 1'b0; flush = 1'b0; sel1 = 1'b0; drv_valid = 1'b0; drv_ready = 1'b0;
    opsel = 3'b000; sub = 1'b0; uns = 1'b0; arith = 1'b0; op1 = '0; op2 = '0;
    tick(); tick();
    rst_n = 1'b1;

    check("rst4.valid", 32'(o_valid4), 32'd0);
    check("rst4.ready", 32'(o_ready4), 32'd1);
    check("rst4.res",   o_res4, 32'd0);
    check("rst1.valid", 32'(o_valid1), 32'd0);
    check("rst1.ready", 32'(o_ready1), 32'd1);
    check("rst1.flags", {30'd0, o_eq1, o_lt1}, 32'd0);

    for (int i = 0; i < 16; i++) run_op(1'b0, vecs[i], $sformatf("vec%0d", i));

    // Full-width arithmetic shift one bit per cycle.
    v = '{3'b101, 1'b0, 1'b0, 1'b1, 32'h80000000, 32'h0000001F, 32'hFFFFFFFF, 1'b0, 1'b1, 32};
    run_op(1'b1, v, "sra31_step1");
    v = '{3'b001, 1'b0, 1'b0, 1'b0, 32'h00000001, 32'h00000005, 32'h00000020, 1'b0, 1'b1, 6};
    run_op(1'b1, v, "sll5_step1");

    // Backpressure: result held while downstream stalls.
    sel1 = 1'b0; opsel = 3'b000; sub = 1'b0; op1 = 32'd2; op2 = 32'd2;
    drv_valid = 1'b1;
    tick();
    drv_valid = 1'b0; op1 = 32'd99; op2 = 32'd77;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp%0d.valid", i), 32'(m_valid), 32'd1);
      check($sformatf("bp%0d.res", i),   m_res, 32'd4);
      check($sformatf("bp%0d.ready", i), 32'(m_ready), 32'd0);
      tick();
    end
    drv_ready = 1'b1;
    tick();
    drv_ready = 1'b0;
    check("bp.drop",  32'(m_valid), 32'd0);
    check("bp.ready", 32'(m_ready), 32'd1);

    // Flush in IDLE blocks accept.
    flush = 1'b1;
    #1;
    check("flush_idle.ready", 32'(m_ready), 32'd0);
    flush = 1'b0;
    #1;

    // Flush mid-shift kills the op.
    opsel = 3'b001; op1 = 32'd1; op2 = 32'd31;
    drv_valid = 1'b1;
    tick();
    drv_valid = 1'b0;
    tick();
    check("flush_shift.valid", 32'(m_valid), 32'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    check("flush_shift.ready", 32'(m_ready), 32'd1);
    rises = 0;
    for (int i = 0; i < 12; i++) begin
      if (m_valid) rises++;
      tick();
    end
    check("flush_shift.never_valid", 32'(rises), 32'd0);

    // Reset mid-shift on the step-1 unit.
    sel1 = 1'b1; opsel = 3'b001; op1 = 32'd1; op2 = 32'd20;
    drv_valid = 1'b1;
    tick();
    drv_valid = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rst_mid.valid", 32'(m_valid), 32'd0);
    check("rst_mid.res",   m_res, 32'd0);
    check("rst_mid.ready", 32'(m_ready), 32'd1);
    v = '{3'b000, 1'b0, 1'b0, 1'b0, 32'd2, 32'd3, 32'd5, 1'b0, 1'b1, 1};
    run_op(1'b1, v, "post_rst_add");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_seq_exec.md
Name: alu_seq_exec

Overview:
- Multi-cycle ALU execute unit. It consumes the control bundle produced by the ALU control decoder (i_opsel, i_sub, i_unsigned, i_arith) plus two operands.
- Area-reduced build of the execute stage: a single-cycle datapath for add/logic/compare, and an iterative shifter that moves SHIFT_STEP bit positions per cycle.
- Sits between decode/register read and writeback. Uses a valid/ready handshake on both sides and a flush input for branch/trap kill.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- SHIFT_STEP, 1, bit positions shifted per cycle; legal values 1, 2, 4, 8, 16, 32.

Ports:
- i_clk  in  1  clock, all state on the rising edge.
- i_rst_n  in  1  synchronous, active-low reset.
- i_valid  in  1  upstream op valid.
- o_ready  out  1  unit can accept an op.
- i_opsel  in  3  000 add/sub, 001 sll, 010 pass op2, 011 slt, 100 xor, 101 shift right, 110 or, 111 and.
- i_sub  in  1  subtract; used only when opsel=000.
- i_unsigned  in  1  unsigned compare; used for opsel=011 and o_lt.
- i_arith  in  1  arithmetic right shift; used only when opsel=101.
- i_op1  in  XLEN  operand A.
- i_op2  in  XLEN  operand B; shift amount is i_op2[4:0].
- i_flush  in  1  kill the in-flight op.
- o_valid  out  1  result valid.
- i_ready  in  1  downstream accepts result.
- o_result  out  XLEN  result.
- o_eq  out  1  op1 == op2 (branch support).
- o_lt  out  1  op1 < op2, signed or unsigned per i_unsigned.

Behaviour:
- Reset: synchronous, active-low. Takes effect on any clock edge with i_rst_n=0, in any state including mid-shift. Sets state=IDLE and o_valid=0, and sets o_result, o_eq, o_lt and the shift counter to 0.
- FSM states: IDLE, SHIFT, DONE.
- o_ready = (state==IDLE) && !i_flush. Accept occurs when i_valid && o_ready. All inputs are captured at accept; later input changes are ignored.
- IDLE, on accept:
  - opsel is not 001/101, or shamt==0: compute result and flags, register them, go to DONE. o_valid rises the next cycle (latency 1).
  - Shift with shamt!=0: load the working register with op1 and the remaining count with shamt, go to SHIFT.
- SHIFT, each cycle:
  - Shift by min(SHIFT_STEP, remaining). Left shifts fill with zero. Right shifts fill with op1[31] if i_arith, else zero.
  - Decrement remaining by the same amount. Go to DONE when remaining reaches 0.
  - Total latency = 1 + ceil(shamt/SHIFT_STEP) cycles from accept to o_valid.
- DONE:
  - o_valid=1. o_result, o_eq and o_lt are held stable until the cycle with i_ready=1.
  - Return to IDLE on i_ready. No back-to-back accept in that same cycle; there is one bubble minimum.
- Arithmetic: add/sub wraps modulo 2^32. Compare is the full 32-bit signed or unsigned comparison. o_eq and o_lt are computed from the captured operands for every opsel.
- slt result: {31'b0, lt}.
- i_flush:
  - In SHIFT or DONE: go to IDLE next cycle and drop o_valid; the result is discarded.
  - In IDLE: blocks accept (o_ready=0).
  - Flush together with i_ready in DONE: treated as consumed; next state is IDLE either way.
- Shift by 31 with arithmetic and op1[31]=1 yields 0xFFFFFFFF.
- shamt uses op2[4:0] only; op2[31:5] is ignored.

Decomposition:
- Shared package alu_pkg holds:
  - opsel localparams (OP_ADD=3'b000, OP_SLL=3'b001, OP_PASSB=3'b010, OP_SLT=3'b011, OP_XOR=3'b100, OP_SR=3'b101, OP_OR=3'b110, OP_AND=3'b111);
  - FSM state encodings (ST_IDLE, ST_SHIFT, ST_DONE);
  - XLEN.
- The ALU control decoder imports the same opsel constants.
- One sub-module: alu_shift_step. Combinational; takes value, direction, fill bit and amount (0..SHIFT_STEP) and returns the shifted value. It is instantiated once in the SHIFT datapath.

Test Plan:
- Add/sub: accept add 0x7FFFFFFF + 1 -> o_valid next cycle with 0x80000000. Sub 5 - 7 -> 0xFFFFFFFE, o_lt=1, o_eq=0.
- Compare: slt with op1=0xFFFFFFFF, op2=1, i_unsigned=0 -> result 1. Same operands with i_unsigned=1 -> result 0 and o_lt=0.
- Arithmetic shift, SHIFT_STEP=1: op1=0x80000000, op2=31, i_arith=1, opsel=101 -> o_valid exactly 32 cycles after accept, result 0xFFFFFFFF.
- Zero and masked shift amounts, SHIFT_STEP=4: sll 0x1 by 0 -> latency 1, result 0x1. Sll 0x1 by 0x23 (shamt=3) -> latency 2, result 0x8.
- Backpressure and flush: hold i_ready=0 for 5 cycles in DONE -> result stable, o_ready=0 throughout. Separately, assert i_flush mid-SHIFT -> o_valid never rises, o_ready=1 two cycles later.
- Reset mid-operation: drive i_rst_n=0 for one edge during SHIFT -> next cycle o_valid=0, o_result=0, o_ready=1. A new add 2+3 then completes with 5.
